// File: rtl/prior_pkg.sv
// prior_pkg: shared definitions for the prior_decoder block.
//   DEFAULT_DATA_WIDTH : default width of the decoded output vector.
//   idx_width()        : derives the index width from a data width.
//   skid_state_e       : occupancy states of the 2-entry skid FIFO.
package prior_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 8;

  // One extra bit beyond what is needed to address DATA_WIDTH bits, so
  // that out-of-range indices can be represented and flagged.
  function automatic int unsigned idx_width(input int unsigned data_width);
    return $clog2(data_width) + 1;
  endfunction

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/prior_skid_buf.sv
// prior_skid_buf: 2-entry valid/ready FIFO (skid buffer) with 1-cycle latency.
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset; discards queued beats
//   in_valid   : upstream beat valid
//   in_ready   : buffer can accept a beat (registered state only)
//   in_data    : upstream payload, WIDTH bits
//   out_valid  : out_data holds a beat
//   out_ready  : downstream accepts the beat
//   out_data   : payload at the head of the queue, WIDTH bits
module prior_skid_buf
  import prior_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  skid_state_e      r_state;
  skid_state_e      w_state_next;
  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_tail;
  logic             w_push;
  logic             w_pop;

  assign w_push = in_valid & in_ready;
  assign w_pop  = out_valid & out_ready;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic. A push in FULL cannot occur because in_ready is low.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      EMPTY: begin
        if (w_push) w_state_next = ONE;
      end
      ONE: begin
        if (w_push && !w_pop)      w_state_next = FULL;
        else if (!w_push && w_pop) w_state_next = EMPTY;
      end
      FULL: begin
        if (w_pop) w_state_next = ONE;
      end
      default: w_state_next = EMPTY;
    endcase
  end

  // Handshake outputs depend on registered state only.
  always_comb begin
    in_ready  = (r_state != FULL);
    out_valid = (r_state != EMPTY);
  end

  // Payload storage. The head register drives out_data directly so the
  // output holds stable while the sink stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_push) r_head <= in_data;
        end
        ONE: begin
          // Push+pop: old head leaves, new beat takes its place.
          if (w_push && w_pop) r_head <= in_data;
          else if (w_push)     r_tail <= in_data;
        end
        FULL: begin
          if (w_pop) r_head <= r_tail;
        end
        default: ;
      endcase
    end
  end

  assign out_data = r_head;

endmodule

// File: rtl/prior_decoder.sv
// prior_decoder: decodes a bit index into a vector, buffered by a 2-entry
// skid FIFO, with a sticky error flag and saturating counter for
// out-of-range indices.
// Build option: define PRIOR_DECODER_THERMO_EN to decode in-range indices
// to a thermometer mask (bits [idx:0] set) instead of one-hot.
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   in_valid   : input beat valid
//   in_ready   : block can accept a beat
//   in_idx     : bit position to decode, INDEX_WIDTH bits
//   in_empty   : source vector had no set bit; in_idx ignored
//   out_valid  : data_out holds a decoded beat
//   out_ready  : sink accepts the beat
//   data_out   : decoded vector, DATA_WIDTH bits
//   err_flag   : sticky, an out-of-range index was accepted
//   err_cnt    : saturating count of out-of-range beats
//   clr_err    : synchronous clear of err_flag and err_cnt
module prior_decoder
  import prior_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int unsigned INDEX_WIDTH   = idx_width(DATA_WIDTH),
  parameter int unsigned ERR_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [INDEX_WIDTH-1:0]   in_idx,
  input  logic                     in_empty,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic                     err_flag,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt,
  input  logic                     clr_err
);

  localparam logic [INDEX_WIDTH-1:0] IdxLimit = INDEX_WIDTH'(DATA_WIDTH);

  logic                     w_accept;
  logic                     w_in_range;
  logic                     w_err_beat;
  logic [DATA_WIDTH-1:0]    w_vec;
  logic                     r_err_flag;
  logic [ERR_CNT_WIDTH-1:0] r_err_cnt;
  logic                     w_err_flag_next;
  logic [ERR_CNT_WIDTH-1:0] w_err_cnt_next;

  assign w_accept   = in_valid & in_ready;
  assign w_in_range = (in_idx < IdxLimit);
  assign w_err_beat = w_accept & ~in_empty & ~w_in_range;

  // Decode at push time; empty and out-of-range beats both store zeros.
  always_comb begin
    w_vec = '0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
`ifdef PRIOR_DECODER_THERMO_EN
      w_vec[i] = ~in_empty & w_in_range & (INDEX_WIDTH'(i) <= in_idx);
`else
      w_vec[i] = ~in_empty & w_in_range & (INDEX_WIDTH'(i) == in_idx);
`endif
    end
  end

  prior_skid_buf #(
    .WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (w_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (data_out)
  );

  // Error tracking. A clear coinciding with an error beat leaves the
  // freshly counted beat visible (flag=1, count=1).
  always_comb begin
    w_err_flag_next = r_err_flag;
    w_err_cnt_next  = r_err_cnt;
    if (clr_err) begin
      w_err_flag_next = w_err_beat;
      w_err_cnt_next  = w_err_beat ? ERR_CNT_WIDTH'(1) : '0;
    end else if (w_err_beat) begin
      w_err_flag_next = 1'b1;
      if (!(&r_err_cnt)) w_err_cnt_next = r_err_cnt + ERR_CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_flag <= 1'b0;
      r_err_cnt  <= '0;
    end else begin
      r_err_flag <= w_err_flag_next;
      r_err_cnt  <= w_err_cnt_next;
    end
  end

  assign err_flag = r_err_flag;
  assign err_cnt  = r_err_cnt;

endmodule

// File: tb/tb_prior_decoder.sv
// tb_prior_decoder: directed, table-driven self-checking bench for prior_decoder
// (DATA_WIDTH=8). Expected values follow the build selected by
// PRIOR_DECODER_THERMO_EN.
module tb_prior_decoder;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_idx;
  logic       in_empty;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] data_out;
  logic       err_flag;
  logic [7:0] err_cnt;
  logic       clr_err;

  int n_pass = 0;
  int n_tot  = 0;

  prior_decoder #(
    .DATA_WIDTH    (8),
    .INDEX_WIDTH   (4),
    .ERR_CNT_WIDTH (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_idx    (in_idx),
    .in_empty  (in_empty),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .err_flag  (err_flag),
    .err_cnt   (err_cnt),
    .clr_err   (clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] idx;
    logic       empty;
    logic [7:0] exp_oh;
    logic [7:0] exp_th;
    logic       exp_flag;
    logic [7:0] exp_cnt;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pick(input logic [7:0] oh, input logic [7:0] th);
`ifdef PRIOR_DECODER_THERMO_EN
    return th;
`else
    return oh;
`endif
  endfunction

  initial begin
    logic [7:0] e;

    vecs[0] = '{4'd0,  1'b0, 8'h01, 8'h01, 1'b0, 8'd0};
    vecs[1] = '{4'd3,  1'b1, 8'h00, 8'h00, 1'b0, 8'd0};
    vecs[2] = '{4'd5,  1'b0, 8'h20, 8'h3F, 1'b0, 8'd0};
    vecs[3] = '{4'd8,  1'b0, 8'h00, 8'h00, 1'b1, 8'd1};
    vecs[4] = '{4'd15, 1'b0, 8'h00, 8'h00, 1'b1, 8'd2};
    vecs[5] = '{4'd3,  1'b0, 8'h08, 8'h0F, 1'b1, 8'd2};
    vecs[6] = '{4'd7,  1'b0, 8'h80, 8'hFF, 1'b1, 8'd2};

    rst = 1'b1; in_valid = 1'b0; in_idx = '0; in_empty = 1'b0;
    out_ready = 1'b0; clr_err = 1'b0;
    step(); step();
    rst = 1'b0;

    // Reset state.
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_data_out",  32'(data_out),  32'd0);
    chk("rst_err_flag",  32'(err_flag),  32'd0);
    chk("rst_err_cnt",   32'(err_cnt),   32'd0);

    // Single beats into an empty buffer; first one lands on the first edge after reset.
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; in_idx = vecs[i].idx; in_empty = vecs[i].empty; out_ready = 1'b1;
      step();
      in_valid = 1'b0; in_empty = 1'b0;
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("vec%0d_data", i),  32'(data_out),
          32'(pick(vecs[i].exp_oh, vecs[i].exp_th)));
      chk($sformatf("vec%0d_flag", i),  32'(err_flag), 32'(vecs[i].exp_flag));
      chk($sformatf("vec%0d_cnt", i),   32'(err_cnt),  32'(vecs[i].exp_cnt));
      step();
      chk($sformatf("vec%0d_drain", i), 32'(out_valid), 32'd0);
    end

    // Back-to-back idx 0..7 at full throughput.
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("b2b%0d_ready", k), 32'(in_ready), 32'd1);
      in_valid = 1'b1; in_idx = 4'(k);
      step();
      e = pick(8'h01 << k, (8'd2 << k) - 8'd1);
      chk($sformatf("b2b%0d_valid", k), 32'(out_valid), 32'd1);
      chk($sformatf("b2b%0d_data", k),  32'(data_out),  32'(e));
    end
    in_valid = 1'b0;
    step();
    chk("b2b_drain", 32'(out_valid), 32'd0);

    // Backpressure: two beats fill the buffer, third waits for the first pop.
    out_ready = 1'b0;
    in_valid = 1'b1; in_idx = 4'd2;
    step();
    in_idx = 4'd5;
    chk("bp_ready_after1", 32'(in_ready), 32'd1);
    step();
    in_idx = 4'd7;
    chk("bp_ready_full", 32'(in_ready), 32'd0);
    chk("bp_head", 32'(data_out), 32'(pick(8'h04, 8'h07)));
    step();
    chk("bp_still_full", 32'(in_ready), 32'd0);
    chk("bp_head_stable", 32'(data_out), 32'(pick(8'h04, 8'h07)));
    out_ready = 1'b1;
    step();
    chk("bp_pop1_data", 32'(data_out), 32'(pick(8'h20, 8'h3F)));
    chk("bp_pop1_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk("bp_idx7_data", 32'(data_out), 32'(pick(8'h80, 8'hFF)));
    chk("bp_idx7_valid", 32'(out_valid), 32'd1);
    step();
    chk("bp_drain", 32'(out_valid), 32'd0);

    // Saturation of the error counter.
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("clr_cnt", 32'(err_cnt), 32'd0);
    chk("clr_flag", 32'(err_flag), 32'd0);
    in_valid = 1'b1; in_idx = 4'd8;
    for (int n = 0; n < 300; n++) step();
    chk("sat_cnt", 32'(err_cnt), 32'd255);
    chk("sat_flag", 32'(err_flag), 32'd1);
    clr_err = 1'b1;
    step();
    in_valid = 1'b0;
    chk("clr_err_coincide_cnt", 32'(err_cnt), 32'd1);
    chk("clr_err_coincide_flag", 32'(err_flag), 32'd1);
    step();
    clr_err = 1'b0;
    chk("clr_alone_cnt", 32'(err_cnt), 32'd0);
    chk("clr_alone_flag", 32'(err_flag), 32'd0);
    step();

    // Reset mid-stream with a full queue and a counted error.
    out_ready = 1'b0;
    in_valid = 1'b1; in_idx = 4'd9;
    step();
    in_idx = 4'd1;
    step();
    in_valid = 1'b0;
    chk("pre_rst_full", 32'(in_ready), 32'd0);
    chk("pre_rst_cnt", 32'(err_cnt), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_cnt", 32'(err_cnt), 32'd0);
    chk("mid_rst_data", 32'(data_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    step();
    chk("post_rst_nostale0", 32'(out_valid), 32'd0);
    step();
    chk("post_rst_nostale1", 32'(out_valid), 32'd0);
    in_valid = 1'b1; in_idx = 4'd4;
    step();
    in_valid = 1'b0;
    chk("post_rst_beat", 32'(data_out), 32'(pick(8'h10, 8'h1F)));
    chk("post_rst_valid", 32'(out_valid), 32'd1);
    step();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
